// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for two requesters in front of a 256x32 data memory.
// Loads extract and extend byte/half lanes; sub-word stores become a read-modify-write.
module dmem_arbiter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [19:0] addr_i,
    input  logic [3:0]  size_i,
    input  logic [1:0]  unsigned_i,
    input  logic [63:0] wdata_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [7:0]  mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_wren_o,
    input  logic [31:0] mem_rdata_i
);
    localparam int NPORT = 2;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state_reg;
    logic        rr_reg;
    logic [7:0]  rmw_addr_reg;
    logic [31:0] rmw_data_reg;
    logic        rmw_port_reg;

    logic [9:0]  p_addr  [NPORT];
    logic [1:0]  p_size  [NPORT];
    logic [31:0] p_wdata [NPORT];

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
            assign p_addr[gi]  = addr_i[10*gi +: 10];
            assign p_size[gi]  = size_i[2*gi +: 2];
            assign p_wdata[gi] = wdata_i[32*gi +: 32];
        end
    endgenerate

    logic        grant;
    logic        win;
    logic [9:0]  sel_addr;
    logic [1:0]  sel_size;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        sel_uns;
    logic        sel_err;
    logic        is_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    always_comb begin
        grant     = (state_reg == IDLE) && rst_ni && (|req_i);
        // With both ports requesting the pointer decides; otherwise the lone requester wins.
        win       = (req_i == 2'b11) ? rr_reg : req_i[1];
        gnt_o     = grant ? (2'b01 << win) : 2'b00;
        sel_addr  = p_addr[win];
        sel_size  = p_size[win];
        sel_wdata = p_wdata[win];
        sel_we    = we_i[win];
        sel_uns   = unsigned_i[win];
        is_word   = (sel_size == 2'b10);
        sel_err   = (sel_size == 2'b11)
                 || ((sel_size == 2'b01) && sel_addr[0])
                 || (is_word && (sel_addr[1:0] != 2'b00));

        lane_byte = mem_rdata_i[{sel_addr[1:0], 3'b000} +: 8];
        lane_half = mem_rdata_i[{sel_addr[1], 4'b0000} +: 16];
        case (sel_size)
            2'b00:   load_data = {{24{~sel_uns & lane_byte[7]}}, lane_byte};
            2'b01:   load_data = {{16{~sel_uns & lane_half[15]}}, lane_half};
            default: load_data = mem_rdata_i;
        endcase

        merged = mem_rdata_i;
        if (sel_size == 2'b00) begin
            merged[{sel_addr[1:0], 3'b000} +: 8] = sel_wdata[7:0];
        end else begin
            merged[{sel_addr[1], 4'b0000} +: 16] = sel_wdata[15:0];
        end

        mem_addr_o  = (state_reg == RMW_WR) ? rmw_addr_reg : sel_addr[9:2];
        mem_wdata_o = (state_reg == RMW_WR) ? rmw_data_reg : sel_wdata;
        mem_wren_o  = rst_ni && ((state_reg == RMW_WR)
                                 || (grant && sel_we && is_word && !sel_err));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            rr_reg       <= 1'b0;
            rvalid_o     <= 2'b00;
            err_o        <= 1'b0;
            rdata_o      <= 32'h0;
            rmw_addr_reg <= 8'h0;
            rmw_data_reg <= 32'h0;
            rmw_port_reg <= 1'b0;
        end else begin
            rvalid_o <= 2'b00;
            err_o    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        rr_reg <= ~win;
                        if (sel_err) begin
                            rvalid_o <= gnt_o;
                            err_o    <= 1'b1;
                            rdata_o  <= 32'h0;
                        end else if (!sel_we) begin
                            rvalid_o <= gnt_o;
                            rdata_o  <= load_data;
                        end else if (is_word) begin
                            rvalid_o <= gnt_o;
                        end else begin
                            // Response for a sub-word store is deferred until the write cycle.
                            state_reg    <= RMW_WR;
                            rmw_addr_reg <= sel_addr[9:2];
                            rmw_data_reg <= merged;
                            rmw_port_reg <= win;
                        end
                    end
                end
                RMW_WR: begin
                    state_reg <= IDLE;
                    rvalid_o  <= 2'b01 << rmw_port_reg;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
